// File: rtl/mlp_mac_unit.sv
// Dot-product MAC stage for the MLP datapath: accumulates (weight, activation) pairs per
// output neuron, then rescales, optionally applies ReLU, saturates and holds one result.
module mlp_mac_unit #(
    parameter int DataWidth  = 8,
    parameter int AccWidth   = 20,
    parameter int FracBits   = 4,
    parameter int MemLatency = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    input  logic                        in_last_i,
    input  logic                        relu_en_i,
    input  logic signed [DataWidth-1:0] w_data_i,
    input  logic signed [DataWidth-1:0] x_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [DataWidth-1:0] out_data_o,
    output logic                        busy_o,
    output logic                        sat_o,
    output logic                        err_o
);

    localparam int ProdWidth = 2 * DataWidth;
    localparam int ExtBits   = AccWidth + 1 - ProdWidth;

    localparam logic signed [AccWidth-1:0] AccMax = {1'b0, {(AccWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] AccMin = {1'b1, {(AccWidth-1){1'b0}}};
    localparam logic signed [AccWidth-1:0] OutMax =
        {{(AccWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
    localparam logic signed [AccWidth-1:0] OutMin = ~OutMax;

    // ------------------------------------------------------------------
    // Tag pipe: carries {valid,last,relu} alongside the memory read so the
    // operands are only sampled once the read data is actually present.
    // ------------------------------------------------------------------
    logic [MemLatency-1:0] tag_valid;
    logic [MemLatency-1:0] tag_last;
    logic [MemLatency-1:0] tag_relu;

    logic d_valid;
    logic d_last;
    logic d_relu;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_valid <= '0;
            tag_last  <= '0;
            tag_relu  <= '0;
        end else begin
            tag_valid[0] <= in_valid_i;
            tag_last[0]  <= in_valid_i & in_last_i;
            tag_relu[0]  <= in_valid_i & in_last_i & relu_en_i;
            for (int i = 1; i < MemLatency; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_relu[i]  <= tag_relu[i-1];
            end
        end
    end

    assign d_valid = tag_valid[MemLatency-1];
    assign d_last  = tag_last[MemLatency-1];
    assign d_relu  = tag_relu[MemLatency-1];

    // ------------------------------------------------------------------
    // Stage M: signed product
    // ------------------------------------------------------------------
    logic signed [ProdWidth-1:0] w_ext;
    logic signed [ProdWidth-1:0] x_ext;
    logic signed [ProdWidth-1:0] product;

    logic                        m_valid;
    logic                        m_last;
    logic                        m_relu;
    logic signed [ProdWidth-1:0] m_prod;

    assign w_ext   = {{DataWidth{w_data_i[DataWidth-1]}}, w_data_i};
    assign x_ext   = {{DataWidth{x_data_i[DataWidth-1]}}, x_data_i};
    assign product = w_ext * x_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_relu  <= 1'b0;
            m_prod  <= '0;
        end else begin
            m_valid <= d_valid;
            m_last  <= d_valid & d_last;
            m_relu  <= d_valid & d_relu;
            // Idle read ports may carry garbage; hold the product instead.
            if (d_valid) begin
                m_prod <= product;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage A: saturating accumulate, rescale, ReLU, clip
    // ------------------------------------------------------------------
    logic signed [AccWidth-1:0] acc;
    logic                       first;
    logic                       grp_sat;

    logic signed [AccWidth-1:0] acc_base;
    logic                       grp_sat_base;
    logic        [AccWidth:0]   sum_wide;
    logic                       acc_ovf;
    logic signed [AccWidth-1:0] acc_next;
    logic signed [AccWidth-1:0] shifted;
    logic signed [AccWidth-1:0] rectified;
    logic                       clipped;
    logic signed [DataWidth-1:0] res_data;
    logic                       res_valid;
    logic                       res_sat;

    always_comb begin
        acc_base     = first ? '0 : acc;
        grp_sat_base = first ? 1'b0 : grp_sat;
        sum_wide     = {acc_base[AccWidth-1], acc_base}
                     + {{ExtBits{m_prod[ProdWidth-1]}}, m_prod};
        acc_ovf      = sum_wide[AccWidth] != sum_wide[AccWidth-1];

        if (!acc_ovf) begin
            acc_next = sum_wide[AccWidth-1:0];
        end else if (sum_wide[AccWidth]) begin
            acc_next = AccMin;
        end else begin
            acc_next = AccMax;
        end

        shifted   = acc_next >>> FracBits;
        rectified = (m_relu && shifted[AccWidth-1]) ? '0 : shifted;

        clipped  = 1'b0;
        res_data = rectified[DataWidth-1:0];
        if (rectified > OutMax) begin
            clipped  = 1'b1;
            res_data = OutMax[DataWidth-1:0];
        end else if (rectified < OutMin) begin
            clipped  = 1'b1;
            res_data = OutMin[DataWidth-1:0];
        end

        res_valid = m_valid & m_last;
        res_sat   = res_valid & (grp_sat_base | acc_ovf | clipped);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            first   <= 1'b1;
            grp_sat <= 1'b0;
        end else if (m_valid) begin
            acc     <= acc_next;
            first   <= m_last;
            grp_sat <= m_last ? 1'b0 : (grp_sat_base | acc_ovf);
        end
    end

    // ------------------------------------------------------------------
    // Output register. valid/ready: a result transfers in any cycle where
    // out_valid_o && out_ready_i; data is held stable until then, and a new
    // result arriving while the register is full and not draining is lost.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            sat_o       <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (res_valid) begin
                if (!out_valid_o || out_ready_i) begin
                    out_valid_o <= 1'b1;
                    out_data_o  <= res_data;
                end else begin
                    err_o <= 1'b1;
                end
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (res_sat) begin
                sat_o <= 1'b1;
            end
        end
    end

    assign busy_o = (|tag_valid) | m_valid | ~first;

endmodule
